// File: rtl/channel_addition_feeder.sv
// SRAM-side feeder for the channel addition core: reads patch words and
// streams them in 4-word bursts, one channel group at a time.
module channel_addition_feeder #(
  parameter int FMS_PATCH_SIZE   = 8,
  parameter int INPUT_DATA_WIDTH = 2,
  parameter int SRAM_SIZE_W      = 8,
  parameter int SRAM_SIZE_H      = 4,
  parameter int ADDR_W           = 15,
  parameter int GRP_W            = 8,
  parameter int BURST_LEN        = 4,
  parameter int GROUP_WORDS_INT4 = 64,
  localparam int DATA_W = SRAM_SIZE_W * SRAM_SIZE_H *
                          FMS_PATCH_SIZE * FMS_PATCH_SIZE *
                          INPUT_DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              quant_mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [GRP_W-1:0]  group_num,
  input  logic              core_idle,
  output logic              sram_rd_en,
  output logic [ADDR_W-1:0] sram_rd_addr,
  input  logic [DATA_W-1:0] sram_rd_data,
  output logic [DATA_W-1:0] sram_data,
  output logic              sram_data_vld,
  output logic              sram_change_vld,
  output logic              chn_add_en,
  output logic              busy,
  output logic              done
);

  localparam int BPG    = GROUP_WORDS_INT4 / BURST_LEN;
  localparam int BCW    = $clog2(2 * BPG) + 1;
  localparam int BEAT_W = $clog2(BURST_LEN);

  typedef enum logic [2:0] {
    IDLE, READ, GAP, CHANGE, HOLD, WAIT_CORE, FINISH
  } state_t;

  state_t state, state_nxt;

  logic              mode_q;
  logic [GRP_W-1:0]  grp_num_q;
  logic [GRP_W-1:0]  grp_cnt;
  logic [ADDR_W-1:0] addr;
  logic [BEAT_W-1:0] beat;
  logic [BCW-1:0]    burst_cnt;
  logic              gap_cnt;
  logic              rd_q1;
  logic              first_q1;
  logic              beat_last;
  logic              grp_end;
  logic              first_rd;

  assign beat_last = beat == BEAT_W'(BURST_LEN - 1);
  assign grp_end   = burst_cnt == (mode_q ? BCW'(2 * BPG) : BCW'(BPG));
  assign first_rd  = (state == READ) && (beat == '0) &&
                     (burst_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (start)
          state_nxt = (group_num == '0) ? FINISH : READ;
      READ:
        if (beat_last) state_nxt = GAP;
      GAP:
        if (gap_cnt) state_nxt = CHANGE;
      CHANGE:
        state_nxt = HOLD;
      HOLD:
        state_nxt = grp_end ? WAIT_CORE : READ;
      WAIT_CORE:
        if (core_idle)
          state_nxt = (grp_cnt == grp_num_q) ? FINISH : READ;
      FINISH:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      grp_num_q <= '0;
      grp_cnt   <= '0;
      addr      <= '0;
      beat      <= '0;
      burst_cnt <= '0;
      gap_cnt   <= 1'b0;
    end else begin
      unique case (1'b1)
        state == IDLE && start: begin
          mode_q    <= quant_mode;
          grp_num_q <= group_num;
          grp_cnt   <= '0;
          addr      <= base_addr;
          beat      <= '0;
          burst_cnt <= '0;
          gap_cnt   <= 1'b0;
        end
        state == READ: begin
          addr <= addr + 1'b1;
          beat <= beat_last ? '0 : beat + 1'b1;
          if (beat_last) burst_cnt <= burst_cnt + 1'b1;
        end
        state == GAP:
          gap_cnt <= ~gap_cnt;
        state == HOLD && grp_end: begin
          grp_cnt   <= grp_cnt + 1'b1;
          burst_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // two-stage read pipe: SRAM latency, then the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q1           <= 1'b0;
      first_q1        <= 1'b0;
      sram_data_vld   <= 1'b0;
      chn_add_en      <= 1'b0;
      sram_change_vld <= 1'b0;
      sram_data       <= '0;
    end else begin
      rd_q1           <= state == READ;
      first_q1        <= first_rd;
      sram_data_vld   <= rd_q1;
      chn_add_en      <= first_q1;
      sram_change_vld <= state == CHANGE;
      if (rd_q1) sram_data <= sram_rd_data;
    end
  end

  assign sram_rd_en   = state == READ;
  assign sram_rd_addr = addr;
  assign busy         = (state != IDLE) && (state != FINISH);
  assign done         = state == FINISH;

endmodule

// File: tb/tb_channel_addition_feeder.sv
// Randomized directed bench for channel_addition_feeder with a
// cycle-level reference model of the burst/group schedule.
module tb_channel_addition_feeder;
  localparam int AW = 15;
  localparam int GW = 8;
  localparam int DW = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          quant_mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [GW-1:0] group_num = '0;
  logic          core_idle = 1'b1;
  logic          sram_rd_en;
  logic [AW-1:0] sram_rd_addr;
  logic [DW-1:0] sram_rd_data = '0;
  logic [DW-1:0] sram_data;
  logic          sram_data_vld, sram_change_vld, chn_add_en;
  logic          busy, done;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int seed = 0;
  int cur_bpg = 16;
  int chg_n = 0;
  int idle_cnt = 0;
  int viol = 0;
  int gap[8];

  int            q_rd_t[$], q_vld_t[$], q_chg_t[$], q_cae_t[$];
  int            q_done_t[$];
  logic [AW-1:0] q_rd_a[$];
  logic [DW-1:0] q_vld_d[$];

  int            e_vld_t[$], e_chg_t[$], e_cae_t[$], e_done_t[$];
  logic [AW-1:0] e_vld_a[$];

  channel_addition_feeder dut (
    .clk(clk), .rst(rst), .start(start), .quant_mode(quant_mode),
    .base_addr(base_addr), .group_num(group_num),
    .core_idle(core_idle), .sram_rd_en(sram_rd_en),
    .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .sram_data(sram_data), .sram_data_vld(sram_data_vld),
    .sram_change_vld(sram_change_vld), .chn_add_en(chn_add_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mem(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++)
      r[i*32 +: 32] = (32'(a) * 32'h9E3779B1) ^ (32'(i) << 20) ^ seed;
    return r;
  endfunction

  always @(posedge clk)
    if (sram_rd_en) sram_rd_data <= mem(sram_rd_addr);

  // observe outputs mid-cycle; also drives core_idle low after a group
  always @(negedge clk) begin
    int r, gi;
    if (!rst) begin
      r = cyc - t0;
      if (sram_rd_en) begin
        q_rd_t.push_back(r);
        q_rd_a.push_back(sram_rd_addr);
      end
      if (sram_data_vld) begin
        q_vld_t.push_back(r);
        q_vld_d.push_back(sram_data);
      end
      if (chn_add_en) q_cae_t.push_back(r);
      if (done) q_done_t.push_back(r);
      if (sram_change_vld && (sram_data_vld || chn_add_en)) viol++;
      if (chn_add_en && !sram_data_vld) viol++;
      if (sram_change_vld) begin
        q_chg_t.push_back(r);
        chg_n++;
        gi = chg_n / cur_bpg - 1;
        if (chg_n % cur_bpg == 0 && gi < 8 && gap[gi] > 0) begin
          core_idle = 1'b0;
          idle_cnt = gap[gi] + 1;
        end
      end else if (idle_cnt > 0) begin
        idle_cnt--;
        if (idle_cnt == 0) core_idle = 1'b1;
      end
    end
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] obs,
                      input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed low %h expected low %h", tag,
             obs[31:0], exp[31:0]);
    end
  endtask

  // schedule derived from the burst rules: 8-cycle burst period,
  // change 2 after last vld, core wait, next group 3 after idle
  task automatic build_exp(input bit q, input int base, input int g);
    int t, nb, l, w, k;
    e_vld_t = {}; e_vld_a = {}; e_chg_t = {};
    e_cae_t = {}; e_done_t = {};
    nb = q ? 32 : 16;
    t = 3;
    k = 0;
    if (g == 0) begin
      e_done_t.push_back(1);
      return;
    end
    for (int gi = 0; gi < g; gi++) begin
      e_cae_t.push_back(t);
      for (int b = 0; b < nb; b++) begin
        for (int i = 0; i < 4; i++) begin
          e_vld_t.push_back(t + 8 * b + i);
          e_vld_a.push_back(AW'((base + k) % 32768));
          k++;
        end
        e_chg_t.push_back(t + 8 * b + 5);
      end
      l = t + 8 * (nb - 1) + 3;
      w = l + 3 + gap[gi];
      if (gi == g - 1) e_done_t.push_back(w + 1);
      else t = w + 3;
    end
  endtask

  task automatic launch(input bit q, input int base, input int g);
    @(negedge clk);
    quant_mode = q;
    base_addr = AW'(base);
    group_num = GW'(g);
    start = 1'b1;
    t0 = cyc;
    q_rd_t = {}; q_rd_a = {}; q_vld_t = {}; q_vld_d = {};
    q_chg_t = {}; q_cae_t = {}; q_done_t = {};
    chg_n = 0;
    idle_cnt = 0;
    core_idle = 1'b1;
    cur_bpg = q ? 32 : 16;
    build_exp(q, base, g);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      #1;
      got = q_done_t.size() > 0;
    end
    chk("done_seen", got, 1);
  endtask

  task automatic check_job(input string nm);
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk({nm, "_n_vld"}, q_vld_t.size(), e_vld_t.size());
    chk({nm, "_n_rd"}, q_rd_t.size(), e_vld_t.size());
    chk({nm, "_n_chg"}, q_chg_t.size(), e_chg_t.size());
    chk({nm, "_n_cae"}, q_cae_t.size(), e_cae_t.size());
    chk({nm, "_n_done"}, q_done_t.size(), 1);
    n = q_vld_t.size() < e_vld_t.size() ? q_vld_t.size()
                                        : e_vld_t.size();
    for (int i = 0; i < n; i++) begin
      chk({nm, "_vld_t"}, q_vld_t[i], e_vld_t[i]);
      chkd({nm, "_data"}, q_vld_d[i], mem(e_vld_a[i]));
    end
    n = q_rd_t.size() < e_vld_t.size() ? q_rd_t.size()
                                       : e_vld_t.size();
    for (int i = 0; i < n; i++) begin
      chk({nm, "_rd_t"}, q_rd_t[i], e_vld_t[i] - 2);
      chk({nm, "_rd_a"}, q_rd_a[i], e_vld_a[i]);
    end
    n = q_chg_t.size() < e_chg_t.size() ? q_chg_t.size()
                                        : e_chg_t.size();
    for (int i = 0; i < n; i++)
      chk({nm, "_chg_t"}, q_chg_t[i], e_chg_t[i]);
    n = q_cae_t.size() < e_cae_t.size() ? q_cae_t.size()
                                        : e_cae_t.size();
    for (int i = 0; i < n; i++)
      chk({nm, "_cae_t"}, q_cae_t[i], e_cae_t[i]);
    if (q_done_t.size() > 0)
      chk({nm, "_done_t"}, q_done_t[0], e_done_t[0]);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_excl"}, viol, 0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rd_en"}, sram_rd_en, 0);
    chk({nm, "_rd_addr"}, sram_rd_addr, 0);
    chk({nm, "_data"}, |sram_data, 0);
    chk({nm, "_vld"}, sram_data_vld, 0);
    chk({nm, "_chg"}, sram_change_vld, 0);
    chk({nm, "_cae"}, chn_add_en, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_done"}, done, 0);
  endtask

  initial begin
    int b;
    bit seen;
    seed = int'($urandom);
    for (int i = 0; i < 8; i++) gap[i] = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    // INT4 single group; start coincident with done must be dropped
    launch(1'b0, 0, 1);
    wait_done();
    start = 1'b1;
    group_num = 1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_at_done_busy", busy, 0);
    chk("start_at_done_rd", sram_rd_en, 0);
    check_job("int4");

    // INT8 two groups, core held busy 20 cycles between groups
    gap[0] = 20;
    gap[1] = int'($urandom_range(0, 5));
    launch(1'b1, int'($urandom_range(0, 32767)), 2);
    wait_done();
    check_job("int8");

    // address wrap
    gap[0] = int'($urandom_range(0, 7));
    launch(1'b0, 32766, 1);
    wait_done();
    check_job("wrap");

    launch(1'b0, int'($urandom_range(0, 32767)), 0);
    wait_done();
    check_job("grp0");

    // second start and mode/base/count changes mid-job
    gap[0] = int'($urandom_range(0, 4));
    gap[1] = int'($urandom_range(0, 4));
    b = int'($urandom_range(0, 32767));
    launch(1'b0, b, 2);
    repeat (30) @(negedge clk);
    start = 1'b1;
    quant_mode = 1'b1;
    base_addr = AW'(b + 1000);
    group_num = 7;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    check_job("ignore");

    // asynchronous reset partway through a burst, then a fresh job
    gap[0] = 0;
    launch(1'b1, int'($urandom_range(0, 32767)), 1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      #1;
      seen = q_vld_t.size() >= 2;
    end
    chk("second_vld_seen", seen, 1);
    rst = 1'b1;
    #1;
    chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b0;
    seed = int'($urandom);
    launch(1'b0, int'($urandom_range(0, 32767)), 1);
    wait_done();
    check_job("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
